// File: rtl/tt_um_taghreed_eialsalman_nand_uart_tx.sv
// tt_um_taghreed_eialsalman_nand_uart_tx: 4-bit NAND of ui_in nibbles, sent as an 8N1 UART frame on uo_out[0].
// Define PARITY_EN to insert an even-parity bit between data and stop.
module tt_um_taghreed_eialsalman_nand_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sync1_q, sync2_q, trig_prev_q;
    logic [3:0]    nand_res;
    logic          trig;
    logic          baud_done;
    logic          unused_ok;

    assign nand_res  = ~(ui_in[7:4] & ui_in[3:0]);
    assign trig      = sync2_q & ~trig_prev_q & ena;
    assign baud_done = baud_q == BAUD_LAST;
    assign uo_out    = {1'b0, nand_res, done_q, busy_q, txd_q};
    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;
    assign unused_ok = &{1'b0, uio_in[7:1]};

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = 3'd0;
                if (trig) begin
                    state_d = START;
                    shift_d = {4'h5, nand_res};
                end
            end
            START: begin
                if (baud_done) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    state_d = STOP;
                    baud_d  = '0;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    state_d = IDLE;
                    baud_d  = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // txd is registered from the next state so the pin never glitches
        txd_d = 1'b1;
        if (state_d == START) txd_d = 1'b0;
        else if (state_d == DATA) txd_d = shift_d[bit_d];
`ifdef PARITY_EN
        else if (state_d == PARITY) txd_d = ^shift_d;
`endif
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sync1_q     <= uio_in[0];
            sync2_q     <= sync1_q;
            trig_prev_q <= sync2_q;
        end
    end
endmodule

// File: tb/tb_tt_um_taghreed_eialsalman_nand_uart_tx.sv
// tb_tt_um_taghreed_eialsalman_nand_uart_tx: directed bench for the NAND UART transmitter tile.
// Honours PARITY_EN when the same macro is defined for the build.
module tb_tt_um_taghreed_eialsalman_nand_uart_tx;
    localparam int CPB = 16;
`ifdef PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tt_um_taghreed_eialsalman_nand_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
        .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raises the send request and checks the start bit lands on the 3rd edge.
    task automatic start(input string tag);
        @(negedge clk);
        uio_in[0] = 1'b1;
        tick();
        chk({tag, " edge1 txd"}, uo_out[0], 1'b1);
        tick();
        chk({tag, " edge2 txd"}, uo_out[0], 1'b1);
        chk({tag, " edge2 busy"}, uo_out[1], 1'b0);
        tick();
        uio_in[0] = 1'b0;
    endtask

    // Called just after the start edge; walks every bit at its first and last cycle.
    task automatic frame(input string tag, input logic [7:0] data);
        logic b[NB];
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = data[i];
`ifdef PARITY_EN
        b[9] = ^data;
`endif
        b[NB-1] = 1'b1;
        for (int i = 0; i < NB; i++) begin
            chk($sformatf("%s bit%0d first", tag, i), uo_out[0], b[i]);
            chk($sformatf("%s busy%0d", tag, i), uo_out[1], 1'b1);
            repeat (CPB - 1) tick();
            chk($sformatf("%s bit%0d last", tag, i), uo_out[0], b[i]);
            chk($sformatf("%s done%0d", tag, i), uo_out[2], 1'b0);
            tick();
        end
        chk({tag, " end busy"}, uo_out[1], 1'b0);
        chk({tag, " end done"}, uo_out[2], 1'b1);
        chk({tag, " end txd"}, uo_out[0], 1'b1);
        tick();
        chk({tag, " done drop"}, uo_out[2], 1'b0);
    endtask

    task automatic quiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (uo_out[0] !== 1'b1 || uo_out[1] !== 1'b0 || uo_out[2] !== 1'b0) seen = 1'b1;
        end
        chk({tag, " quiet"}, seen, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset txd", uo_out[0], 1'b1);
        chk("reset busy", uo_out[1], 1'b0);
        chk("reset done", uo_out[2], 1'b0);
        chk("uio_oe", uio_oe, 8'h00);
        chk("uio_out", uio_out, 8'h00);
        quiet("post reset", 5);

        ui_in = 8'hC6;
        #1;
        chk("live C6", uo_out[6:3], 4'b1011);
        chk("bit7", uo_out[7], 1'b0);
        start("f1");
        frame("f1", 8'h5B);

        ui_in = 8'hFF;
        start("cap");
        ui_in = 8'h00;
        #1;
        chk("live 00", uo_out[6:3], 4'b1111);
        frame("cap", 8'h50);

        ui_in = 8'hC6;
        start("busy");
        fork
            frame("busy", 8'h5B);
            begin
                repeat (40) @(negedge clk);
                uio_in[0] = 1'b1;
                repeat (4) @(negedge clk);
                uio_in[0] = 1'b0;
            end
        join
        quiet("no queue", 30);
        ui_in = 8'hA3;
        start("again");
        frame("again", 8'h5D);

        ena = 1'b0;
        @(negedge clk);
        uio_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        uio_in[0] = 1'b0;
        quiet("ena0", 200);
        ena = 1'b1;

        ui_in = 8'h33;
        start("enadrop");
        fork
            frame("enadrop", 8'h5C);
            begin
                repeat (30) @(negedge clk);
                ena = 1'b0;
            end
        join
        ena = 1'b1;

        start("rst");
        repeat (50) tick();
        chk("rst pre busy", uo_out[1], 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async txd", uo_out[0], 1'b1);
        chk("async busy", uo_out[1], 1'b0);
        chk("async done", uo_out[2], 1'b0);
        chk("async oe", uio_oe, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet("after rst", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
